// File: rtl/mux_rr_2to1.sv
// mux_rr_2to1
//
// Recombines two byte lanes, previously split by the 1:2 byte demux, back into
// a single byte stream. Each lane is buffered in its own small FIFO so that
// skew between the lanes, up to DEPTH bytes, is absorbed. The output drains
// the FIFOs in strict alternation (lane 0, lane 1, lane 0, ...). If the lane
// whose turn it is has nothing buffered, the output idles rather than skipping
// ahead, so the original byte order is always restored.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset
//   in0        - lane 0 byte,  in0_valid - lane 0 byte present this cycle
//   in1        - lane 1 byte,  in1_valid - lane 1 byte present this cycle
//   out0       - recombined byte (registered, holds while valid_out0=0)
//   valid_out0 - out0 carries a new byte (registered)
//   fifo0_cnt  - lane 0 FIFO occupancy, 0..DEPTH
//   fifo1_cnt  - lane 1 FIFO occupancy, 0..DEPTH
//   overflow   - sticky: a lane byte was dropped on a full FIFO

module mux_rr_2to1 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in0,
    input  logic              in0_valid,
    input  logic [DATA_W-1:0] in1,
    input  logic              in1_valid,
    output logic [DATA_W-1:0] out0,
    output logic              valid_out0,
    output logic [CNT_W-1:0]  fifo0_cnt,
    output logic [CNT_W-1:0]  fifo1_cnt,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Per-lane FIFO state; index 0 is lane 0, index 1 is lane 1.
    logic [1:0][PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0][PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]     mem_q [2][DEPTH];

    // Lane whose head is emitted next.
    logic                  sel_q, sel_d;

    logic [DATA_W-1:0]     out_q, out_d;
    logic                  vld_q, vld_d;
    logic                  ovf_q, ovf_d;

    logic [1:0]            in_vld;
    logic [1:0]            push;
    logic [1:0]            pop;

    assign in_vld = {in1_valid, in0_valid};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        out_d    = out_q;
        vld_d    = 1'b0;
        ovf_d    = ovf_q;
        push     = '0;
        pop      = '0;

        // Only the selected lane may pop; an empty selected lane stalls the
        // output so that bytes are never reordered.
        if (cnt_q[sel_q] != '0) begin
            pop[sel_q] = 1'b1;
            out_d      = mem_q[sel_q][rd_ptr_q[sel_q]];
            vld_d      = 1'b1;
            sel_d      = ~sel_q;
        end

        for (int i = 0; i < 2; i++) begin
            // A full FIFO still accepts a byte when its head leaves on the
            // same edge, since one slot frees up as the new byte lands.
            if (in_vld[i]) begin
                if ((cnt_q[i] != FULL_CNT) || pop[i]) begin
                    push[i] = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end

            if (push[i]) begin
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
            end

            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!push[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            out_q    <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            out_q    <= out_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written,
    // because the occupancy counts are reset.
    always_ff @(posedge clk) begin
        if (push[0]) begin
            mem_q[0][wr_ptr_q[0]] <= in0;
        end
        if (push[1]) begin
            mem_q[1][wr_ptr_q[1]] <= in1;
        end
    end

    assign out0       = out_q;
    assign valid_out0 = vld_q;
    assign fifo0_cnt  = cnt_q[0];
    assign fifo1_cnt  = cnt_q[1];
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_mux_rr_2to1.sv
// tb_mux_rr_2to1
//
// Directed bench for mux_rr_2to1. A queue-based model of the two lane FIFOs
// and the alternating drain runs alongside the DUT; a compare process checks
// every DUT output against it each cycle. Directed scenarios additionally pin
// specific outputs and the emitted byte sequence to hand-computed literals.

module tb_mux_rr_2to1;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] in0 = '0;
    logic              in0_valid = 1'b0;
    logic [DATA_W-1:0] in1 = '0;
    logic              in1_valid = 1'b0;
    logic [DATA_W-1:0] out0;
    logic              valid_out0;
    logic [CNT_W-1:0]  fifo0_cnt;
    logic [CNT_W-1:0]  fifo1_cnt;
    logic              overflow;

    mux_rr_2to1 #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in0       (in0),
        .in0_valid (in0_valid),
        .in1       (in1),
        .in1_valid (in1_valid),
        .out0      (out0),
        .valid_out0(valid_out0),
        .fifo0_cnt (fifo0_cnt),
        .fifo1_cnt (fifo1_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    // Bytes seen on the output while valid, in order.
    logic [7:0] got[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         m_turn1 = 1'b0;   // 1 when lane 1 is owed the next output byte
    bit         m_ovf = 1'b0;
    bit         m_vld = 1'b0;
    logic [7:0] m_out = '0;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                q0.delete();
                q1.delete();
                m_turn1 = 1'b0;
                m_ovf   = 1'b0;
                m_vld   = 1'b0;
                m_out   = '0;
            end else begin
                // Output side sees the queues as they were before this edge.
                m_vld = 1'b0;
                if (!m_turn1 && q0.size() > 0) begin
                    m_out   = q0.pop_front();
                    m_vld   = 1'b1;
                    m_turn1 = 1'b1;
                end else if (m_turn1 && q1.size() > 0) begin
                    m_out   = q1.pop_front();
                    m_vld   = 1'b1;
                    m_turn1 = 1'b0;
                end
                if (in0_valid) begin
                    if (q0.size() < DEPTH) q0.push_back(in0);
                    else m_ovf = 1'b1;
                end
                if (in1_valid) begin
                    if (q1.size() < DEPTH) q1.push_back(in1);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                check("valid_out0", valid_out0, m_vld);
                check("out0", out0, m_out);
                check("fifo0_cnt", fifo0_cnt, q0.size());
                check("fifo1_cnt", fifo1_cnt, q1.size());
                check("overflow", overflow, m_ovf);
                if (valid_out0 === 1'b1) got.push_back(out0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
        in0_valid = v0;
        in0       = d0;
        in1_valid = v1;
        in1       = d1;
        @(posedge clk);
        #1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
    endtask

    task automatic idle();
        tick(1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        got.delete();
    endtask

    task automatic expect_seq(input string name, input logic [7:0] exp[$]);
        @(negedge clk);
        #1;
        check({name, " length"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
        end
        got.delete();
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [7:0] exp[$];

        #2 reset = 1'b0;
        #1;
        check("reset out0", out0, 8'h00);
        check("reset valid_out0", valid_out0, 1'b0);
        check("reset fifo0_cnt", fifo0_cnt, 0);
        check("reset fifo1_cnt", fifo1_cnt, 0);
        check("reset overflow", overflow, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        checking = 1'b1;
        got.delete();

        // Alternating stream.
        tick(1, 8'h10, 0, 8'h00);
        check("alt first valid", valid_out0, 1'b0);
        tick(0, 8'h00, 1, 8'h11);
        check("alt first out", out0, 8'h10);
        tick(1, 8'h12, 0, 8'h00);
        tick(0, 8'h00, 1, 8'h13);
        tick(1, 8'h14, 0, 8'h00);
        tick(0, 8'h00, 1, 8'h15);
        check("alt out 0x14", out0, 8'h14);
        idle();
        check("alt last out", out0, 8'h15);
        check("alt last valid", valid_out0, 1'b1);
        idle();
        check("alt hold out", out0, 8'h15);
        check("alt idle valid", valid_out0, 1'b0);
        exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        expect_seq("alt seq", exp);

        // Skew: lane 1 runs ahead of lane 0.
        tick(0, 8'h00, 1, 8'hB1);
        tick(0, 8'h00, 1, 8'hB2);
        check("skew fifo1_cnt peak", fifo1_cnt, 2);
        idle();
        tick(1, 8'hA1, 0, 8'h00);
        check("skew stalled valid", valid_out0, 1'b0);
        idle();
        check("skew A1 out", out0, 8'hA1);
        tick(1, 8'hA2, 0, 8'h00);
        check("skew B1 out", out0, 8'hB1);
        idle();
        idle();
        idle();
        exp = '{8'hA1, 8'hB1, 8'hA2, 8'hB2};
        expect_seq("skew seq", exp);

        // Full FIFO pushed and popped on the same edge.
        do_reset();
        tick(1, 8'hE0, 0, 8'h00);
        idle();
        tick(1, 8'hE1, 0, 8'h00);
        tick(1, 8'hE2, 0, 8'h00);
        tick(1, 8'hE3, 0, 8'h00);
        tick(1, 8'hE4, 1, 8'hF0);
        check("full fifo0_cnt", fifo0_cnt, 4);
        idle();
        check("full F0 out", out0, 8'hF0);
        check("full still 4", fifo0_cnt, 4);
        tick(1, 8'h55, 0, 8'h00);
        check("pushpop out", out0, 8'hE1);
        check("pushpop fifo0_cnt", fifo0_cnt, 4);
        check("pushpop overflow", overflow, 1'b0);
        exp = '{8'hE0, 8'hF0, 8'hE1};
        expect_seq("pushpop seq", exp);

        // Overflow: lane 0 fills while lane 1 is owed the next byte.
        do_reset();
        tick(1, 8'hC0, 0, 8'h00);
        idle();
        for (int i = 1; i <= 5; i++) tick(1, 8'hC0 + 8'(i), 0, 8'h00);
        check("ovf fifo0_cnt", fifo0_cnt, 4);
        check("ovf set", overflow, 1'b1);
        tick(0, 8'h00, 1, 8'hD1);
        idle();
        idle();
        check("ovf sticky", overflow, 1'b1);
        check("ovf fifo0_cnt after", fifo0_cnt, 3);
        exp = '{8'hC0, 8'hD1, 8'hC1};
        expect_seq("ovf seq", exp);

        // Wrap-around: 20 balanced pairs.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick(1, 8'(2 * i), 1, 8'(2 * i + 1));
            idle();
        end
        idle();
        idle();
        check("wrap overflow", overflow, 1'b0);
        exp.delete();
        for (int i = 0; i < 40; i++) exp.push_back(8'(i));
        expect_seq("wrap seq", exp);

        // Reset in the middle of a stream.
        do_reset();
        tick(1, 8'h60, 1, 8'h61);
        tick(1, 8'h62, 1, 8'h63);
        check("mid out before reset", out0, 8'h60);
        check("mid fifo1 before reset", fifo1_cnt, 2);
        #2 reset = 1'b0;
        #1;
        check("mid reset out0", out0, 8'h00);
        check("mid reset valid", valid_out0, 1'b0);
        check("mid reset fifo0_cnt", fifo0_cnt, 0);
        check("mid reset fifo1_cnt", fifo1_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        got.delete();
        tick(1, 8'h70, 1, 8'h71);
        idle();
        check("mid first from lane0", out0, 8'h70);
        idle();
        idle();
        exp = '{8'h70, 8'h71};
        expect_seq("mid seq", exp);

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
